// File: rtl/k6502_bus_responder_pkg.sv
// k6502_bus_defs: shared I/O page layout, status bit positions and default
// addresses for the k6502 bus responder.
package k6502_bus_defs;

    localparam logic [15:0] IO_BASE_DEF   = 16'h7F00;
    localparam logic [15:0] HALT_ADDR_DEF = 16'hDEAD;

    typedef enum logic [7:0] {
        IO_TXDATA = 8'h00,
        IO_STATUS = 8'h01,
        IO_COUNT  = 8'h02,
        IO_CNT0   = 8'h04,
        IO_CNT1   = 8'h05,
        IO_CNT2   = 8'h06,
        IO_CNT3   = 8'h07
    } io_reg_e;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;

    function automatic logic [7:0] status_byte(input logic ovf, input logic full, input logic empty);
        logic [7:0] s;
        s           = 8'h00;
        s[ST_EMPTY] = empty;
        s[ST_FULL]  = full;
        s[ST_OVF]   = ovf;
        return s;
    endfunction

endpackage

// File: rtl/k6502_bus_responder_if.sv
// k6502_bus_responder_if: CPU bus plus the TX byte stream seen by the responder.
interface k6502_bus_responder_if;
    logic [15:0] a;
    logic        rw;
    logic [7:0]  d_in;
    logic [7:0]  d_out;
    logic        d_oe;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport slave  (input a, rw, d_in, tx_ready, output d_out, d_oe, tx_data, tx_valid);
    modport master (output a, rw, d_in, tx_ready, input d_out, d_oe, tx_data, tx_valid);
endinterface

// File: rtl/k6502_bus_responder_fifo.sv
// k6502_sync_fifo: synchronous FIFO with registered storage, no fall-through,
// and a push that is accepted when full if a pop happens in the same cycle.
module k6502_sync_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o,
    output logic          push_ok_o
);
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  mem_q [2**AW];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic          pop;

    assign empty_o   = level_q == '0;
    assign full_o    = level_q == DEPTH;
    assign pop       = pop_i && !empty_o;
    assign push_ok_o = push_i && (!full_o || pop);
    assign level_o   = level_q;
    assign level_d   = level_q + (AW+1)'(push_ok_o) - (AW+1)'(pop);
    // Empty reads as zero so the head byte is defined straight out of reset.
    assign rdata_o   = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst_n && push_ok_o) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok_o) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end
endmodule

// File: rtl/k6502_bus_responder.sv
// k6502_bus_responder: mirrored scratch RAM, I/O page (TX FIFO, status,
// tear-free cycle counter) and a write-once halt latch on the k6502 bus.
module k6502_bus_responder
    import k6502_bus_defs::*;
#(
    parameter int          RAM_AW    = 11,
    parameter int          FIFO_AW   = 4,
    parameter logic [15:0] IO_BASE   = IO_BASE_DEF,
    parameter logic [15:0] HALT_ADDR = HALT_ADDR_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    k6502_bus_responder_if.slave bus,
    output logic                 halt,
    output logic [7:0]           halt_code
);
    logic [7:0]       ram_q [2**RAM_AW];
    logic [31:0]      cnt_q;
    logic [23:0]      snap_q;
    logic             ovf_q, halt_q;
    logic [7:0]       halt_code_q;
    logic             is_ram, is_io, is_halt, wr, rd, push, push_ok, full, empty;
    logic [7:0]       off, rd_io;
    logic [FIFO_AW:0] level;

    assign off       = bus.a[7:0];
    assign is_ram    = bus.a < IO_BASE;
    assign is_io     = bus.a[15:8] == IO_BASE[15:8];
    assign is_halt   = bus.a == HALT_ADDR;
    // Once halted the CPU can no longer change anything in this block.
    assign wr        = rst_n && bus.rw && !halt_q;
    assign rd        = rst_n && !bus.rw;
    assign push      = wr && is_io && off == IO_TXDATA;
    assign halt      = halt_q;
    assign halt_code = halt_code_q;

    k6502_sync_fifo #(.W(8), .AW(FIFO_AW)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (push),
        .pop_i     (bus.tx_ready),
        .wdata_i   (bus.d_in),
        .rdata_o   (bus.tx_data),
        .full_o    (full),
        .empty_o   (empty),
        .level_o   (level),
        .push_ok_o (push_ok)
    );
    assign bus.tx_valid = !empty;

    always_comb begin
        case (off)
            IO_STATUS: rd_io = status_byte(ovf_q, full, empty);
            IO_COUNT:  rd_io = 8'(level);
            IO_CNT0:   rd_io = cnt_q[7:0];
            IO_CNT1:   rd_io = snap_q[7:0];
            IO_CNT2:   rd_io = snap_q[15:8];
            IO_CNT3:   rd_io = snap_q[23:16];
            default:   rd_io = 8'h00;
        endcase
    end

    assign bus.d_oe  = rd && (is_ram || is_io);
    assign bus.d_out = !bus.d_oe ? 8'h00 : is_io ? rd_io : ram_q[bus.a[RAM_AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr && is_ram) ram_q[bus.a[RAM_AW-1:0]] <= bus.d_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            snap_q      <= '0;
            ovf_q       <= 1'b0;
            halt_q      <= 1'b0;
            halt_code_q <= '0;
        end else begin
            cnt_q <= cnt_q + 32'd1;
            // Reading the low byte freezes the upper bytes for a tear-free read.
            if (rd && is_io && off == IO_CNT0) snap_q <= cnt_q[31:8];
            if (push && !push_ok) ovf_q <= 1'b1;
            else if (wr && is_io && off == IO_STATUS) ovf_q <= 1'b0;
            if (wr && is_halt) begin
                halt_q      <= 1'b1;
                halt_code_q <= bus.d_in;
            end
        end
    end
endmodule

// File: tb/tb_k6502_bus_responder.sv
// tb_k6502_bus_responder: directed vectors, corner sequences and random bus
// traffic checked against a queue-based model of the responder.
module tb_k6502_bus_responder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       halt;
    logic [7:0] halt_code;

    k6502_bus_responder_if bus();
    k6502_bus_responder dut (.clk(clk), .rst_n(rst_n), .bus(bus), .halt(halt), .halt_code(halt_code));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  m_ram [2048];
    bit          m_known [2048];
    logic [7:0]  m_q [$];
    bit          m_ovf = 0, m_halt = 0;
    logic [7:0]  m_code = 0;
    logic [31:0] m_cnt = 0;
    logic [23:0] m_snap = 0;

    logic [7:0] last_dout, last_txd, last_code;
    logic       last_oe, last_txv, last_halt;

    typedef struct {
        logic [15:0] a;
        logic        rw;
        logic [7:0]  d;
        logic        oe;
        logic [7:0]  dout;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected {d_oe, d_out} for the current cycle, from the model state.
    function automatic logic [8:0] m_read(input logic [15:0] a, input logic rw);
        int lv;
        lv = m_q.size();
        if (!rst_n || rw) return 9'h000;
        if (a < 16'h7F00) return {1'b1, m_ram[a[10:0]]};
        if (a[15:8] != 8'h7F) return 9'h000;
        case (a[7:0])
            8'h01:   return {1'b1, 5'b0, m_ovf, lv == 16, lv == 0};
            8'h02:   return {1'b1, 8'(lv)};
            8'h04:   return {1'b1, m_cnt[7:0]};
            8'h05:   return {1'b1, m_snap[7:0]};
            8'h06:   return {1'b1, m_snap[15:8]};
            8'h07:   return {1'b1, m_snap[23:16]};
            default: return 9'h100;
        endcase
    endfunction

    task automatic m_step(input logic [15:0] a, input logic rw, input logic [7:0] d, input logic rdy);
        bit pop, wr, io;
        if (!rst_n) begin
            m_q.delete();
            m_ovf  = 0;
            m_halt = 0;
            m_code = 0;
            m_cnt  = 0;
            m_snap = 0;
            return;
        end
        pop = m_q.size() > 0 && rdy;
        wr  = rw && !m_halt;
        io  = a[15:8] == 8'h7F;
        if (!rw && io && a[7:0] == 8'h04) m_snap = m_cnt[31:8];
        if (pop) void'(m_q.pop_front());
        if (wr && a < 16'h7F00) begin
            m_ram[a[10:0]]   = d;
            m_known[a[10:0]] = 1;
        end
        if (wr && io && a[7:0] == 8'h01) m_ovf = 0;
        if (wr && io && a[7:0] == 8'h00) begin
            if (m_q.size() < 16) m_q.push_back(d);
            else m_ovf = 1;
        end
        if (wr && a == 16'hDEAD) begin
            m_halt = 1;
            m_code = d;
        end
        m_cnt++;
    endtask

    // One bus cycle: drive at negedge, check just after, update model at posedge.
    task automatic cyc(input logic [15:0] a, input logic rw, input logic [7:0] d, input logic rdy);
        logic [8:0] e;
        bus.a = a;
        bus.rw = rw;
        bus.d_in = d;
        bus.tx_ready = rdy;
        #1;
        last_dout = bus.d_out;
        last_oe   = bus.d_oe;
        last_txd  = bus.tx_data;
        last_txv  = bus.tx_valid;
        last_halt = halt;
        last_code = halt_code;
        e = m_read(a, rw);
        chk("d_oe", bus.d_oe, e[8]);
        if (!(e[8] && a < 16'h7F00 && !m_known[a[10:0]])) chk("d_out", bus.d_out, e[7:0]);
        chk("tx_valid", bus.tx_valid, m_q.size() > 0);
        if (m_q.size() > 0) chk("tx_data", bus.tx_data, m_q[0]);
        chk("halt", halt, m_halt);
        chk("halt_code", halt_code, m_code);
        @(posedge clk);
        m_step(a, rw, d, rdy);
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] ra;
        logic        rrw;
        bus.a = 16'h9000;
        bus.rw = 1'b0;
        bus.d_in = 8'h00;
        bus.tx_ready = 1'b0;
        tbl[0]  = '{16'h0123, 1'b1, 8'h5A, 1'b0, 8'h00};
        tbl[1]  = '{16'h0123, 1'b0, 8'h00, 1'b1, 8'h5A};
        tbl[2]  = '{16'h0923, 1'b0, 8'h00, 1'b1, 8'h5A};
        tbl[3]  = '{16'h9000, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[4]  = '{16'hDEAD, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[5]  = '{16'h7F03, 1'b0, 8'h00, 1'b1, 8'h00};
        tbl[6]  = '{16'h7F00, 1'b1, 8'h48, 1'b0, 8'h00};
        tbl[7]  = '{16'h7F00, 1'b1, 8'h69, 1'b0, 8'h00};
        tbl[8]  = '{16'h7F01, 1'b0, 8'h00, 1'b1, 8'h00};
        tbl[9]  = '{16'h7F02, 1'b0, 8'h00, 1'b1, 8'h02};
        tbl[10] = '{16'h7F00, 1'b0, 8'h00, 1'b1, 8'h00};

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        cyc(16'h0123, 1'b0, 8'h00, 1'b0);
        chk("rst_d_oe", last_oe, 1'b0);
        chk("rst_tx_valid", last_txv, 1'b0);
        chk("rst_tx_data", last_txd, 8'h00);
        chk("rst_halt", last_halt, 1'b0);
        chk("rst_halt_code", last_code, 8'h00);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].a, tbl[i].rw, tbl[i].d, 1'b0);
            chk($sformatf("vec%0d_oe", i), last_oe, tbl[i].oe);
            chk($sformatf("vec%0d_dout", i), last_dout, tbl[i].dout);
        end

        cyc(16'h9000, 1'b0, 8'h00, 1'b1);
        chk("drain0", last_txd, 8'h48);
        cyc(16'h9000, 1'b0, 8'h00, 1'b1);
        chk("drain1", last_txd, 8'h69);
        cyc(16'h7F01, 1'b0, 8'h00, 1'b1);
        chk("drained_valid", last_txv, 1'b0);
        chk("drained_status", last_dout, 8'h01);

        for (int i = 0; i < 17; i++) cyc(16'h7F00, 1'b1, 8'(8'h10 + i), 1'b0);
        cyc(16'h7F02, 1'b0, 8'h00, 1'b0);
        chk("ovf_count", last_dout, 8'h10);
        cyc(16'h7F01, 1'b0, 8'h00, 1'b0);
        chk("ovf_status", last_dout, 8'h06);
        cyc(16'h7F01, 1'b1, 8'hFF, 1'b0);
        cyc(16'h7F01, 1'b0, 8'h00, 1'b0);
        chk("ovf_cleared", last_dout, 8'h02);
        for (int i = 0; i < 16; i++) begin
            cyc(16'h9000, 1'b0, 8'h00, 1'b1);
            chk($sformatf("ovf_drain%0d", i), last_txd, 8'(8'h10 + i));
        end

        for (int i = 0; i < 16; i++) cyc(16'h7F00, 1'b1, 8'(8'h20 + i), 1'b0);
        cyc(16'h7F00, 1'b1, 8'hAB, 1'b1);
        chk("pp_popped", last_txd, 8'h20);
        cyc(16'h7F02, 1'b0, 8'h00, 1'b0);
        chk("pp_count", last_dout, 8'h10);
        cyc(16'h7F01, 1'b0, 8'h00, 1'b0);
        chk("pp_status", last_dout, 8'h02);
        for (int i = 0; i < 16; i++) begin
            cyc(16'h9000, 1'b0, 8'h00, 1'b1);
            chk($sformatf("pp_drain%0d", i), last_txd, i < 15 ? 8'(8'h21 + i) : 8'hAB);
        end

        cyc(16'h7F00, 1'b1, 8'h55, 1'b0);
        cyc(16'h9000, 1'b0, 8'h00, 1'b0);
        chk("pre_rst_valid", last_txv, 1'b1);
        rst_n = 1'b0;
        cyc(16'h0123, 1'b0, 8'h00, 1'b1);
        chk("in_rst_oe", last_oe, 1'b0);
        rst_n = 1'b1;
        cyc(16'h7F04, 1'b0, 8'h00, 1'b0);
        chk("post_rst_cnt0", last_dout, 8'h00);
        chk("post_rst_valid", last_txv, 1'b0);
        cyc(16'h7F02, 1'b0, 8'h00, 1'b0);
        chk("post_rst_count", last_dout, 8'h00);
        for (int k = 0; k < 400 && m_cnt != 32'hFF; k++) cyc(16'h9000, 1'b0, 8'h00, 1'b0);
        chk("cnt_reach_ff", m_cnt, 32'hFF);
        cyc(16'h7F04, 1'b0, 8'h00, 1'b0);
        chk("tear_cnt0", last_dout, 8'hFF);
        cyc(16'h7F05, 1'b0, 8'h00, 1'b0);
        chk("tear_cnt1", last_dout, 8'h00);
        cyc(16'h7F06, 1'b0, 8'h00, 1'b0);
        chk("tear_cnt2", last_dout, 8'h00);
        cyc(16'h7F07, 1'b0, 8'h00, 1'b0);
        chk("tear_cnt3", last_dout, 8'h00);

        for (int i = 0; i < 2000; i++) begin
            rrw = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0, 1, 2: ra = 16'($urandom_range(0, 32'h7EFF));
                3:       ra = {2'b00, 3'($urandom_range(0, 7)), 11'($urandom_range(0, 31))};
                4, 5, 6: ra = 16'h7F00 | 16'($urandom_range(0, 8));
                7: begin
                    ra  = 16'h7F00;
                    rrw = 1'b1;
                end
                8:       ra = 16'h7F01;
                default: ra = 16'($urandom_range(32'h8000, 32'hFFFF));
            endcase
            if (ra == 16'hDEAD) ra = 16'h9000;
            cyc(ra, rrw, 8'($urandom), $urandom_range(0, 7) < (((i / 256) % 2) != 0 ? 1 : 6));
        end

        for (int i = 0; i < 20; i++) cyc(16'h9000, 1'b0, 8'h00, 1'b1);
        cyc(16'h0010, 1'b1, 8'h33, 1'b0);
        cyc(16'hDEAD, 1'b1, 8'h42, 1'b0);
        cyc(16'h0010, 1'b1, 8'h77, 1'b0);
        chk("halt_set", last_halt, 1'b1);
        chk("halt_code_set", last_code, 8'h42);
        cyc(16'h0010, 1'b0, 8'h00, 1'b0);
        chk("halt_ram_kept", last_dout, 8'h33);
        cyc(16'hDEAD, 1'b1, 8'h00, 1'b0);
        cyc(16'h7F00, 1'b1, 8'h99, 1'b0);
        cyc(16'h7F02, 1'b0, 8'h00, 1'b0);
        chk("halt_no_push", last_dout, 8'h00);
        chk("halt_code_kept", last_code, 8'h42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
